// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: opcodes, 2-bit counter encodings and the
// saturating counter step used by the history table.
package bp_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } bht_cnt_e;

  localparam logic [1:0] CNT_RESET = CNT_WNT;

  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == CNT_ST) res = CNT_ST;
      else               res = cnt + 2'd1;
    end else begin
      if (cnt == CNT_SNT) res = CNT_SNT;
      else                res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Array of 2-bit saturating direction counters: one combinational read port,
// one synchronous update port, whole-table synchronous reset.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] cnt_q [ENTRIES];

  // Read sees the pre-edge value, so a same-cycle update never disturbs the lookup.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  // Counter storage: reset to weak-not-taken, otherwise saturating update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RESET;
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= cnt_step(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/bp_bht.sv
// Next-fetch-PC predictor: JAL always taken, B-type by counter table when
// BP_BHT_DYNAMIC_EN is defined, otherwise backward-taken/forward-not-taken.
module bp_bht
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = 256,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            iIC_En,
  input  logic [31:0]     iIC_Ins,
  input  logic [XLEN-1:0] iIF_Pc,
  input  logic            iBR_En,
  input  logic [XLEN-1:0] iBR_Pc,
  input  logic            iBR_Taken,
  output logic            oIF_En,
  output logic [XLEN-1:0] oIF_Pcn,
  output logic            oIF_PredTaken
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [6:0]      opcode_s;
  logic [XLEN-1:0] imm_j_s, imm_b_s;
  logic [XLEN-1:0] pc_seq_s, tgt_j_s, tgt_b_s;
  logic            br_taken_s;
  logic            pred_taken_s;
  logic [XLEN-1:0] pred_pc_s;
  logic            en_q, en_d;
  logic [XLEN-1:0] pcn_q, pcn_d;
  logic            pt_q, pt_d;

  assign opcode_s = iIC_Ins[6:0];
  assign imm_j_s  = {{(XLEN-20){iIC_Ins[31]}}, iIC_Ins[19:12], iIC_Ins[20], iIC_Ins[30:21], 1'b0};
  assign imm_b_s  = {{(XLEN-12){iIC_Ins[31]}}, iIC_Ins[7], iIC_Ins[30:25], iIC_Ins[11:8], 1'b0};
  assign pc_seq_s = iIF_Pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign tgt_j_s  = iIF_Pc + imm_j_s;
  assign tgt_b_s  = iIF_Pc + imm_b_s;

`ifdef BP_BHT_DYNAMIC_EN
  logic [1:0] rd_cnt_s;
  logic       unused_s;

  bp_counter_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (iIF_Pc[IDX_W+1:2]),
    .rd_cnt_o    (rd_cnt_s),
    .upd_en_i    (en & iBR_En),
    .upd_idx_i   (iBR_Pc[IDX_W+1:2]),
    .upd_taken_i (iBR_Taken)
  );

  assign br_taken_s = rd_cnt_s[1];
  assign unused_s   = ^{iBR_Pc[XLEN-1:IDX_W+2], iBR_Pc[1:0]};
`else
  logic unused_s;

  // Static fallback: the immediate's sign bit is the branch direction.
  assign br_taken_s = iIC_Ins[31];
  assign unused_s   = ^{iBR_En, iBR_Pc, iBR_Taken};
`endif

  // Opcode decode into predicted direction and next PC.
  always_comb begin
    pred_taken_s = 1'b0;
    pred_pc_s    = pc_seq_s;
    case (opcode_s)
      OPC_JAL: begin
        pred_taken_s = 1'b1;
        pred_pc_s    = tgt_j_s;
      end
      OPC_BRANCH: begin
        pred_taken_s = br_taken_s;
        if (br_taken_s) pred_pc_s = tgt_b_s;
        else            pred_pc_s = pc_seq_s;
      end
      default: begin
        pred_taken_s = 1'b0;
        pred_pc_s    = pc_seq_s;
      end
    endcase
  end

  // Output next-state: capture on accepted fetch, drop valid on idle fetch, hold when disabled.
  always_comb begin
    en_d  = en_q;
    pcn_d = pcn_q;
    pt_d  = pt_q;
    if (en) begin
      if (iIC_En) begin
        en_d  = 1'b1;
        pcn_d = pred_pc_s;
        pt_d  = pred_taken_s;
      end else begin
        en_d  = 1'b0;
        pcn_d = pcn_q;
        pt_d  = pt_q;
      end
    end else begin
      en_d  = en_q;
      pcn_d = pcn_q;
      pt_d  = pt_q;
    end
  end

  // Output registers; reset raises oIF_En to kick the first fetch from PC 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b1;
      pcn_q <= {XLEN{1'b0}};
      pt_q  <= 1'b0;
    end else begin
      en_q  <= en_d;
      pcn_q <= pcn_d;
      pt_q  <= pt_d;
    end
  end

  assign oIF_En        = en_q;
  assign oIF_Pcn       = pcn_q;
  assign oIF_PredTaken = pt_q;

endmodule

// File: tb/tb_bp_bht.sv
// Self-checking bench for bp_bht: directed vector table, hand sequences for the
// counter corner cases, then random traffic against a behavioural model.
module tb_bp_bht;

  localparam int ENTRIES = 16;
  localparam int XLEN    = 32;
`ifdef BP_BHT_DYNAMIC_EN
  localparam bit DYN = 1'b1;
`else
  localparam bit DYN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, ic_en, br_en, br_t;
  logic [31:0] ins, pc_v, br_pc;
  logic        o_en, o_pt;
  logic [31:0] o_pcn;

  always #5 clk = ~clk;

  bp_bht #(.BHT_ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .iIC_En        (ic_en),
    .iIC_Ins       (ins),
    .iIF_Pc        (pc_v),
    .iBR_En        (br_en),
    .iBR_Pc        (br_pc),
    .iBR_Taken     (br_t),
    .oIF_En        (o_en),
    .oIF_Pcn       (o_pcn),
    .oIF_PredTaken (o_pt)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: expected outputs and one integer counter per table slot.
  bit          m_en;
  logic [31:0] m_pcn;
  bit          m_pt;
  int          m_cnt [ENTRIES];

  logic [6:0] other_opc [6];

  typedef struct {
    bit          e;
    bit          ic;
    logic [31:0] pc;
    int          kind;
    int          off;
    bit          be;
    logic [31:0] bp;
    bit          bt;
    bit          x_en;
    logic [31:0] x_pcn;
    bit          x_pt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Builds an instruction of the given kind (0 other, 1 JAL, 2 B-type, 3 JALR) with random filler.
  function automatic logic [31:0] enc(input int kind, input logic [31:0] off);
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 5);
    case (kind)
      1:       enc = {off[20], off[10:1], off[11], off[19:12], r[11:7], 7'b1101111};
      2:       enc = {off[12], off[10:5], r[24:20], r[19:15], r[14:12], off[4:1], off[11], 7'b1100011};
      3:       enc = {r[31:7], 7'b1100111};
      default: enc = {r[31:7], other_opc[k]};
    endcase
  endfunction

  task automatic step(input bit r, input bit e, input bit ic, input logic [31:0] p,
                      input int kind, input logic [31:0] off,
                      input bit be, input logic [31:0] bp, input bit bt);
    int idx;
    bit tk;
    @(negedge clk);
    rst = r; en = e; ic_en = ic; pc_v = p; ins = enc(kind, off);
    br_en = be; br_pc = bp; br_t = bt;
    if (r) begin
      m_en = 1'b1; m_pcn = 32'h0; m_pt = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 1;
    end else if (e) begin
      if (ic) begin
        idx = int'((p >> 2) % 32'(ENTRIES));
        case (kind)
          1:       tk = 1'b1;
          2:       tk = DYN ? (m_cnt[idx] >= 2) : ($signed(off) < 0);
          default: tk = 1'b0;
        endcase
        m_en  = 1'b1;
        m_pt  = tk;
        m_pcn = tk ? p + off : p + 32'd4;
      end else begin
        m_en = 1'b0;
      end
      if (be && DYN) begin
        idx = int'((bp >> 2) % 32'(ENTRIES));
        if (bt) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
        else    m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
      end
    end
    @(posedge clk);
    #1;
    chk("model_en",  {31'd0, o_en}, {31'd0, m_en});
    chk("model_pcn", o_pcn, m_pcn);
    chk("model_pt",  {31'd0, o_pt}, {31'd0, m_pt});
  endtask

  initial begin
    other_opc = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b1110011};
    rst = 1'b1; en = 1'b0; ic_en = 1'b0; ins = 32'h0; pc_v = 32'h0;
    br_en = 1'b0; br_pc = 32'h0; br_t = 1'b0;

    tbl[0]  = '{1, 1, 32'h100,      1, 32'h20,   0, 0,     0, 1, 32'h120, 1};
    tbl[1]  = '{1, 1, 32'h200,      2, -8,       0, 0,     0, 1, DYN ? 32'h204 : 32'h1F8, !DYN};
    tbl[2]  = '{1, 0, 32'h300,      1, 32'h40,   0, 0,     0, 0, 32'h0, 0};
    tbl[3]  = '{1, 1, 32'hFFFFFFFC, 0, 0,        0, 0,     0, 1, 32'h0, 0};
    tbl[4]  = '{0, 1, 32'h500,      1, 32'h40,   1, 32'h40, 1, 1, 32'h0, 0};
    tbl[5]  = '{0, 1, 32'h500,      1, 32'h40,   1, 32'h40, 1, 1, 32'h0, 0};
    tbl[6]  = '{0, 1, 32'h500,      1, 32'h40,   1, 32'h40, 1, 1, 32'h0, 0};
    tbl[7]  = '{1, 1, 32'h40,       2, 32'h10,   0, 0,     0, 1, 32'h44, 0};
    tbl[8]  = '{1, 1, 32'h40,       2, -16,      0, 0,     0, 1, DYN ? 32'h44 : 32'h30, !DYN};
    tbl[9]  = '{1, 1, 32'h80,       3, 0,        0, 0,     0, 1, 32'h84, 0};
    tbl[10] = '{1, 1, 32'h1000,     1, -256,     0, 0,     0, 1, 32'hF00, 1};
    tbl[11] = '{1, 1, 32'hFFFFFFF0, 1, 32'h20,   0, 0,     0, 1, 32'h10, 1};
    tbl[2].x_pcn = tbl[1].x_pcn;
    tbl[2].x_pt  = tbl[1].x_pt;

    // Reset wins over a coincident JAL lookup and counter update.
    step(1, 1, 1, 32'h100, 1, 32'h20, 1, 32'h100, 1);
    chk("rst_en",  {31'd0, o_en}, 32'd1);
    chk("rst_pcn", o_pcn, 32'h0);
    chk("rst_pt",  {31'd0, o_pt}, 32'd0);
    step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);

    for (int i = 0; i < 12; i++) begin
      step(0, tbl[i].e, tbl[i].ic, tbl[i].pc, tbl[i].kind, tbl[i].off, tbl[i].be, tbl[i].bp, tbl[i].bt);
      chk($sformatf("tbl%0d_en", i),  {31'd0, o_en}, {31'd0, tbl[i].x_en});
      chk($sformatf("tbl%0d_pcn", i), o_pcn, tbl[i].x_pcn);
      chk($sformatf("tbl%0d_pt", i),  {31'd0, o_pt}, {31'd0, tbl[i].x_pt});
    end

`ifdef BP_BHT_DYNAMIC_EN
    // Training to strong-taken, saturation, then one not-taken step.
    step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 32'h0, 0, 0, 1, 32'h200, 1);
    step(0, 1, 1, 32'h200, 2, -8, 0, 32'h0, 0);
    chk("train_pcn", o_pcn, 32'h1F8);
    chk("train_pt",  {31'd0, o_pt}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 0, 0, 1, 32'h200, 1);
    step(0, 1, 0, 32'h0, 0, 0, 1, 32'h200, 0);
    step(0, 1, 1, 32'h200, 2, -8, 0, 32'h0, 0);
    chk("sat_pt", {31'd0, o_pt}, 32'd1);

    // Lookup and not-taken update of the same entry in one cycle.
    step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 0, 1, 32'h300, 1);
    step(0, 1, 1, 32'h300, 2, 32'h40, 1, 32'h300, 0);
    chk("rbw_pt",  {31'd0, o_pt}, 32'd1);
    chk("rbw_pcn", o_pcn, 32'h340);
    step(0, 1, 1, 32'h300, 2, 32'h40, 0, 32'h0, 0);
    chk("rbw_after_pt", {31'd0, o_pt}, 32'd0);

    // 0x40 and 0x80 share entry 0 of a 16-entry table.
    step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0, 0, 1, 32'h40, 1);
    step(0, 1, 0, 32'h0, 0, 0, 1, 32'h80, 1);
    step(0, 1, 1, 32'h0, 2, 32'h10, 0, 32'h0, 0);
    chk("alias_pt",  {31'd0, o_pt}, 32'd1);
    chk("alias_pcn", o_pcn, 32'h10);
`else
    // Resolution updates have no effect on the static predictor.
    step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 0, 0, 1, 32'h40, 1);
    step(0, 1, 1, 32'h40, 2, 32'h10, 0, 32'h0, 0);
    chk("btfn_fwd_pt",  {31'd0, o_pt}, 32'd0);
    chk("btfn_fwd_pcn", o_pcn, 32'h44);
    step(0, 1, 1, 32'h40, 2, -16, 0, 32'h0, 0);
    chk("btfn_bwd_pt",  {31'd0, o_pt}, 32'd1);
    chk("btfn_bwd_pcn", o_pcn, 32'h30);
`endif

    for (int n = 0; n < 600; n++) begin
      bit          r, e, ic, be, bt;
      int          kind;
      logic [31:0] p, off, bp;
      r    = ($urandom_range(0, 99) == 0);
      e    = ($urandom_range(0, 9) != 0);
      ic   = ($urandom_range(0, 4) != 0);
      kind = $urandom_range(0, 3);
      p    = ($urandom_range(0, 1) == 1) ? $urandom() : (32'($urandom_range(0, 63)) << 2);
      case (kind)
        1:       off = 32'(($urandom_range(0, 1048575) - 524288) * 2);
        2:       off = 32'(($urandom_range(0, 4095) - 2048) * 2);
        default: off = 32'h0;
      endcase
      be = ($urandom_range(0, 1) == 1);
      bt = ($urandom_range(0, 1) == 1);
      bp = 32'($urandom_range(0, 63)) << 2;
      step(r, e, ic, p, kind, off, be, bp, bt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
